// File: rtl/jk_counter_bank.sv
// jk_counter_bank: WIDTH-bit bank of edge-triggered JK flip-flops sharing a mode
// select. Each edge applies per-bit JK, up-count, down-count or parallel load.
// Inputs are only sampled on the rising edge, so pulses between edges are ignored.

// Per-bit JK next-state cell: hold, set, clear or toggle.
module jk_cell (
    input  logic j,
    input  logic k,
    input  logic q,
    output logic d
);
    // JK characteristic table for one bit
    always_comb begin
        d = q;
        unique case ({j, k})
            2'b00:   d = q;
            2'b10:   d = 1'b1;
            2'b01:   d = 1'b0;
            2'b11:   d = ~q;
            default: d = q;
        endcase
    end
endmodule

module jk_counter_bank #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               MAX_COUNT = (1 << WIDTH) - 1,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_,
    output logic             tc,
    output logic             ovf
);
    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    mode_e            mode_s;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;
    logic             at_max;
    logic             at_zero;
    logic             above_max;

    assign mode_s    = mode_e'(mode);
    assign at_max    = (q >= MAX_V);
    assign at_zero   = (q == '0);
    assign above_max = (q > MAX_V);

    // One JK cell per bit; the cells only see the register, never a latch
    // stage, so there is no ones-catching path.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .j (j[i]),
            .k (k[i]),
            .q (q[i]),
            .d (jk_next[i])
        );
    end

    // Next state and limit pulse for the current mode
    always_comb begin
        q_nxt   = q;
        ovf_nxt = 1'b0;
        if (en) begin
            unique case (mode_s)
                MODE_JK: q_nxt = jk_next;
                MODE_UP: begin
                    // Values above the limit (from JK or load) also wrap to 0.
                    if (at_max) begin
                        q_nxt   = SATURATE ? MAX_V : '0;
                        ovf_nxt = 1'b1;
                    end else begin
                        q_nxt = q + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    // An out-of-range value is pulled back to the limit first.
                    if (above_max) begin
                        q_nxt   = MAX_V;
                        ovf_nxt = 1'b1;
                    end else if (at_zero) begin
                        q_nxt   = SATURATE ? '0 : MAX_V;
                        ovf_nxt = 1'b1;
                    end else begin
                        q_nxt = q - 1'b1;
                    end
                end
                MODE_LOAD: q_nxt = j;
                default:   q_nxt = q;
            endcase
        end
    end

    // State register; reset wins immediately regardless of the clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q   <= RESET_VAL;
            ovf <= 1'b0;
        end else begin
            q   <= q_nxt;
            ovf <= ovf_nxt;
        end
    end

    // Complement comes straight off the same register, so no skew between them
    assign q_ = ~q;

    // Terminal count tracks q and the live mode input
    assign tc = ((mode_s == MODE_UP) && at_max) || ((mode_s == MODE_DOWN) && at_zero);

endmodule

// File: tb/tb_jk_counter_bank.sv
// Bench for jk_counter_bank: a wrapping instance (MAX_COUNT=9) and a saturating
// instance (MAX_COUNT=15, RESET_VAL=3) share one stimulus stream and are both
// compared to an arithmetic reference model each cycle.
module tb_jk_counter_bank;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j, k;
    logic [W-1:0] q_w, qn_w, q_s, qn_s;
    logic         tc_w, ovf_w, tc_s, ovf_s;

    int checks   = 0;
    int failures = 0;

    // model state per instance: 0 = wrap, 1 = saturate
    int mq [2];
    int mo [2];
    int maxc [2] = '{9, 15};
    int satc [2] = '{0, 1};
    int rstv [2] = '{0, 3};

    typedef struct {
        bit       en;
        bit [1:0] mode;
        bit [3:0] j;
        bit [3:0] k;
        bit [3:0] eq;
        bit       eovf;
        bit       etc;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    jk_counter_bank #(.WIDTH(W), .RESET_VAL(4'd0), .MAX_COUNT(9), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .j(j), .k(k),
        .q(q_w), .q_(qn_w), .tc(tc_w), .ovf(ovf_w)
    );

    jk_counter_bank #(.WIDTH(W), .RESET_VAL(4'd3), .MAX_COUNT(15), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .j(j), .k(k),
        .q(q_s), .q_(qn_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int tc_model(input int qv, input int md, input int mx);
        return ((md == 1 && qv >= mx) || (md == 2 && qv == 0)) ? 1 : 0;
    endfunction

    // Reference rules, written as plain integer arithmetic per instance
    task automatic model_edge(input bit e, input int md, input int jv, input int kv);
        for (int i = 0; i < 2; i++) begin
            mo[i] = 0;
            if (e) begin
                case (md)
                    0: begin
                        int nq;
                        nq = 0;
                        for (int b = 0; b < W; b++) begin
                            int qb, jb, kb, nb;
                            qb = (mq[i] >> b) & 1;
                            jb = (jv >> b) & 1;
                            kb = (kv >> b) & 1;
                            if (jb == 0 && kb == 0)      nb = qb;
                            else if (jb == 1 && kb == 0) nb = 1;
                            else if (jb == 0 && kb == 1) nb = 0;
                            else                         nb = 1 - qb;
                            nq += nb << b;
                        end
                        mq[i] = nq;
                    end
                    1: begin
                        if (mq[i] >= maxc[i]) begin
                            mq[i] = satc[i] ? maxc[i] : 0;
                            mo[i] = 1;
                        end else mq[i] = mq[i] + 1;
                    end
                    2: begin
                        if (mq[i] > maxc[i]) begin
                            mq[i] = maxc[i];
                            mo[i] = 1;
                        end else if (mq[i] == 0) begin
                            mq[i] = satc[i] ? 0 : maxc[i];
                            mo[i] = 1;
                        end else mq[i] = mq[i] - 1;
                    end
                    default: mq[i] = jv;
                endcase
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".w.q"},   32'(q_w),   32'(mq[0]));
        chk({tag, ".w.q_"},  32'(qn_w),  32'(~mq[0] & 15));
        chk({tag, ".w.ovf"}, 32'(ovf_w), 32'(mo[0]));
        chk({tag, ".w.tc"},  32'(tc_w),  32'(tc_model(mq[0], int'(mode), maxc[0])));
        chk({tag, ".s.q"},   32'(q_s),   32'(mq[1]));
        chk({tag, ".s.q_"},  32'(qn_s),  32'(~mq[1] & 15));
        chk({tag, ".s.ovf"}, 32'(ovf_s), 32'(mo[1]));
        chk({tag, ".s.tc"},  32'(tc_s),  32'(tc_model(mq[1], int'(mode), maxc[1])));
    endtask

    // Drive inputs away from the edge, take one edge, check 1ns later
    task automatic cyc(input bit e, input logic [1:0] md, input logic [3:0] jv,
                       input logic [3:0] kv, input string tag);
        en = e; mode = md; j = jv; k = kv;
        @(posedge clk);
        model_edge(e, int'(md), int'(jv), int'(kv));
        #1;
        check_all(tag);
    endtask

    // Pull reset low between edges and check it lands before the next edge
    task automatic mid_reset(input string tag);
        #3 reset_n = 1'b0;
        #1;
        mq[0] = rstv[0]; mo[0] = 0;
        mq[1] = rstv[1]; mo[1] = 0;
        chk({tag, ".w.q"},   32'(q_w),   32'(rstv[0]));
        chk({tag, ".s.q"},   32'(q_s),   32'(rstv[1]));
        chk({tag, ".w.ovf"}, 32'(ovf_w), 32'd0);
        chk({tag, ".s.ovf"}, 32'(ovf_s), 32'd0);
        #1 reset_n = 1'b1;
        cyc(1'b0, 2'b00, 4'd0, 4'd0, {tag, ".post"});
    endtask

    initial begin
        logic [3:0] held_w, held_s;

        // wrap-instance vectors from q=0; tc evaluated with the vector's mode held
        tbl[0]  = '{1, 2'b11, 4'd8,     4'd0,     4'd8,     0, 0};
        tbl[1]  = '{1, 2'b01, 4'd0,     4'd0,     4'd9,     0, 1};
        tbl[2]  = '{1, 2'b01, 4'd0,     4'd0,     4'd0,     1, 0};
        tbl[3]  = '{1, 2'b10, 4'd0,     4'd0,     4'd9,     1, 0};
        tbl[4]  = '{0, 2'b10, 4'd0,     4'd0,     4'd9,     0, 0};
        tbl[5]  = '{1, 2'b11, 4'd14,    4'd0,     4'd14,    0, 0};
        tbl[6]  = '{1, 2'b10, 4'd0,     4'd0,     4'd9,     1, 0};
        tbl[7]  = '{1, 2'b11, 4'd14,    4'd0,     4'd14,    0, 0};
        tbl[8]  = '{1, 2'b01, 4'd0,     4'd0,     4'd0,     1, 0};
        tbl[9]  = '{1, 2'b00, 4'b1100,  4'b1010,  4'b1100,  0, 0};
        // from 1100: bit3 toggles, bit2 clears, bit1 toggles, bit0 clears
        tbl[10] = '{1, 2'b00, 4'b1010,  4'b1111,  4'b0010,  0, 0};
        tbl[11] = '{1, 2'b10, 4'd0,     4'd0,     4'd1,     0, 0};
        tbl[12] = '{1, 2'b10, 4'd0,     4'd0,     4'd0,     0, 1};

        reset_n = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0;
        mq[0] = rstv[0]; mo[0] = 0; mq[1] = rstv[1]; mo[1] = 0;
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        #3 reset_n = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 0, 0, 0);
        #1;
        check_all("release");

        // force both to 0 so the table starts from a known value
        cyc(1'b1, 2'b11, 4'd0, 4'd0, "init");
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].en, tbl[i].mode, tbl[i].j, tbl[i].k, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.q", i),   32'(q_w),   32'(tbl[i].eq));
            chk($sformatf("vec%0d.ovf", i), 32'(ovf_w), 32'(tbl[i].eovf));
            chk($sformatf("vec%0d.tc", i),  32'(tc_w),  32'(tbl[i].etc));
        end

        // reset in the middle of a count
        cyc(1'b1, 2'b11, 4'd0, 4'd0, "cnt.ld");
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'b01, 4'd0, 4'd0, "cnt.up");
        chk("cnt5.w.q", 32'(q_w), 32'd5);
        mid_reset("rst_mid");

        // reset while ovf is high
        cyc(1'b1, 2'b11, 4'd15, 4'd0, "ovf.ld");
        cyc(1'b1, 2'b01, 4'd0, 4'd0, "ovf.up");
        chk("ovf.s.pre", 32'(ovf_s), 32'd1);
        mid_reset("rst_ovf");

        // saturation: sits at 15 with ovf every enabled edge, drops when en=0
        cyc(1'b1, 2'b11, 4'd15, 4'd0, "sat.ld");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b01, 4'd0, 4'd0, "sat.up");
            chk("sat.s.q",   32'(q_s),   32'd15);
            chk("sat.s.ovf", 32'(ovf_s), 32'd1);
            chk("sat.s.tc",  32'(tc_s),  32'd1);
        end
        cyc(1'b0, 2'b01, 4'd0, 4'd0, "sat.hold");
        chk("sat.hold.q",   32'(q_s),   32'd15);
        chk("sat.hold.ovf", 32'(ovf_s), 32'd0);
        cyc(1'b1, 2'b11, 4'd0, 4'd0, "satdn.ld");
        cyc(1'b1, 2'b10, 4'd0, 4'd0, "satdn");
        chk("satdn.s.q",   32'(q_s),   32'd0);
        chk("satdn.s.ovf", 32'(ovf_s), 32'd1);

        // short j pulse while clk is high, well clear of any rising edge
        cyc(1'b1, 2'b11, 4'd5, 4'd0, "gl.ld");
        cyc(1'b1, 2'b00, 4'd0, 4'd0, "gl.hold");
        held_w = q_w; held_s = q_s;
        #1 j = 4'hF;
        #1 j = 4'h0;
        cyc(1'b1, 2'b00, 4'd0, 4'd0, "gl.after");
        chk("glitch.w.q", 32'(q_w), 32'(held_w));
        chk("glitch.s.q", 32'(q_s), 32'(held_s));
        chk("glitch.w.v", 32'(q_w), 32'd5);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                4'($urandom), 4'($urandom), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
